led_bank: RTL and testbench
===========================

# led_bank

Parametrised LED output peripheral for the myrisc16 board tops. It replaces the hard-wired mapping of CPU output bits to LEDs with a small write/read register bank that the core drives over a simple strobe bus. Each LED channel has on/off, blink and global PWM dimming, all derived from one free-running prescaler. The board top instantiates it between the myrisc16 core and the LED pins.

## Interface

- NUM_LEDS, 5, number of LED channels; 1..DATA_WIDTH
- DATA_WIDTH, 16, bus data width
- PWM_BITS, 4, brightness resolution; 1..PRESCALE_BITS-3
- PRESCALE_BITS, 22, prescaler width; ≥4 (2^22 clocks ≈ 0.35 s at 12 MHz)

- in_clock  input  1  single clock, all logic rising-edge
- in_reset  input  1  asynchronous, active-high; clears all state
- in_wr_en  input  1  write strobe, one write per cycle it is high
- in_rd_en  input  1  read strobe
- in_addr  input  2  register select
- in_wr_data  input  DATA_WIDTH  write data
- out_rd_data  output  DATA_WIDTH  registered read data
- out_led  output  NUM_LEDS  registered LED drive, 1 = lit

## Operation

- Registers (all reset to 0):
  - addr 0 ON: bits [NUM_LEDS-1:0], channel enable
  - addr 1 BLINK: bits [NUM_LEDS-1:0], channel blink enable
  - addr 2 BRIGHT: bits [PWM_BITS-1:0], global duty
  - addr 3 DIV: bits [1:0], blink rate select
- Bits written above a register's width are discarded; reads return 0 in those bits.
- Prescaler: free-running PRESCALE_BITS counter, +1 every cycle, wraps from all-ones to 0 with no stall.
- pwm_cnt = prescaler[PWM_BITS-1:0].
- pwm_on = 1 if BRIGHT is all-ones, else (pwm_cnt < BRIGHT), unsigned compare.
- BRIGHT = 0 forces all LEDs dark.
- blink_phase = prescaler[PRESCALE_BITS-1-DIV]. DIV = 3 blinks 8x faster than DIV = 0.
- Next out_led[i] = ON[i] & (~BLINK[i] | blink_phase) & pwm_on.
- Read: when in_rd_en is high, out_rd_data loads the addressed register at the same edge. Otherwise out_rd_data holds its value.
- Simultaneous read and write of the same address: out_rd_data returns the pre-write value.
- There is no handshake. Every strobe completes in one cycle.

## Timing

- Write at edge k: the register holds the new value after edge k, and out_led reflects it after edge k+1 (1-cycle latency).
- Read at edge k: out_rd_data is valid after edge k.
- pwm_cnt and blink_phase are sampled from the prescaler value present before the edge. out_led therefore lags the prescaler by one cycle.
- PWM period is 2^PWM_BITS cycles. Blink period is 2^(PRESCALE_BITS-DIV) cycles at 50% duty.
- Changing DIV mid-period takes effect on the next edge. A glitch in the blink phase is permitted.
- Assertion of in_reset at any time: prescaler, registers, out_led and out_rd_data go to 0 immediately, with no clock needed. Strobes are ignored while reset is high.
- After deassertion, the first edge starts the prescaler at 0 → 1.

## Test plan

Bench parameters: NUM_LEDS=5, PWM_BITS=2, PRESCALE_BITS=8.

- Reset: assert in_reset mid-run with ON=0x1F and BRIGHT=3 → out_led=0 and out_rd_data=0 without a clock edge. After release, reading addr 0 returns 0.
- Direct drive: write ON=0x15, BRIGHT=3 → out_led=5'b10101 one cycle after the write and steady. Write ON=0xFFFF → read returns 0x001F.
- PWM: ON=0x01, BRIGHT=1 → out_led[0] high 1 cycle in every 4. BRIGHT=2 → 2 of 4. BRIGHT=0 → never lit.
- Blink: ON=0x03, BLINK=0x02, BRIGHT=3, DIV=0 → led[0] constant 1, led[1] toggles every 128 cycles. DIV=3 → toggles every 16 cycles.
- Read/write collision: ON=0x0A, then in the same cycle write ON=0x05 and read addr 0 → out_rd_data=0x000A. A next read returns 0x0005.
- Prescaler wrap: run 600 cycles with BLINK set → blink period stays exactly 256 cycles across wraps, with no missing or extra toggle.

Source files
------------

// File: rtl/led_bank.sv
`default_nettype none
// ============================================================================
// Module   : led_bank
// Summary  : Register-mapped LED driver with per-channel on/off and blink,
//            plus global PWM dimming, all timed from one free-running prescaler.
// Revision : 1.0
// ============================================================================
module led_bank #(
    parameter int NUM_LEDS      = 5,
    parameter int DATA_WIDTH    = 16,
    parameter int PWM_BITS      = 4,
    parameter int PRESCALE_BITS = 22
) (
    input  logic                  in_clock,
    input  logic                  in_reset,
    input  logic                  in_wr_en,
    input  logic                  in_rd_en,
    input  logic [1:0]            in_addr,
    input  logic [DATA_WIDTH-1:0] in_wr_data,
    output logic [DATA_WIDTH-1:0] out_rd_data,
    output logic [NUM_LEDS-1:0]   out_led
);

    localparam logic [1:0] c_addr_on     = 2'd0;
    localparam logic [1:0] c_addr_blink  = 2'd1;
    localparam logic [1:0] c_addr_bright = 2'd2;
    localparam logic [1:0] c_addr_div    = 2'd3;

    localparam logic [PRESCALE_BITS-1:0] c_prescale_one = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

    logic [PRESCALE_BITS-1:0] r_prescaler;
    logic [NUM_LEDS-1:0]      r_on;
    logic [NUM_LEDS-1:0]      r_blink;
    logic [PWM_BITS-1:0]      r_bright;
    logic [1:0]               r_div;
    logic [DATA_WIDTH-1:0]    r_rd_data;
    logic [NUM_LEDS-1:0]      r_led;

    logic [PWM_BITS-1:0]      w_pwm_cnt;
    logic                     w_pwm_on;
    logic                     w_blink_phase;
    logic [NUM_LEDS-1:0]      w_led_next;
    logic [DATA_WIDTH-1:0]    w_rd_mux;
    logic                     w_unused_wr_data;

    // Upper write-data bits beyond each register's width are simply dropped.
    assign w_unused_wr_data = ^in_wr_data;

    assign w_pwm_cnt = r_prescaler[PWM_BITS-1:0];
    // Full-scale brightness must stay lit for the whole period, so it bypasses the compare.
    assign w_pwm_on  = (&r_bright) | (w_pwm_cnt < r_bright);

    always_comb begin
        w_blink_phase = r_prescaler[PRESCALE_BITS-1];
        case (r_div)
            2'd0:    w_blink_phase = r_prescaler[PRESCALE_BITS-1];
            2'd1:    w_blink_phase = r_prescaler[PRESCALE_BITS-2];
            2'd2:    w_blink_phase = r_prescaler[PRESCALE_BITS-3];
            2'd3:    w_blink_phase = r_prescaler[PRESCALE_BITS-4];
            default: w_blink_phase = r_prescaler[PRESCALE_BITS-1];
        endcase
    end

    assign w_led_next = r_on
                      & (~r_blink | {NUM_LEDS{w_blink_phase}})
                      & {NUM_LEDS{w_pwm_on}};

    always_comb begin
        w_rd_mux = '0;
        case (in_addr)
            c_addr_on:     w_rd_mux[NUM_LEDS-1:0] = r_on;
            c_addr_blink:  w_rd_mux[NUM_LEDS-1:0] = r_blink;
            c_addr_bright: w_rd_mux[PWM_BITS-1:0] = r_bright;
            c_addr_div:    w_rd_mux[1:0]          = r_div;
            default:       w_rd_mux               = '0;
        endcase
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_prescaler <= '0;
            r_on        <= '0;
            r_blink     <= '0;
            r_bright    <= '0;
            r_div       <= '0;
            r_rd_data   <= '0;
            r_led       <= '0;
        end else begin
            r_prescaler <= r_prescaler + c_prescale_one;
            r_led       <= w_led_next;

            // The read mux sees pre-edge register values, so a colliding write is not visible yet.
            if (in_rd_en) begin
                r_rd_data <= w_rd_mux;
            end

            if (in_wr_en) begin
                case (in_addr)
                    c_addr_on:     r_on     <= in_wr_data[NUM_LEDS-1:0];
                    c_addr_blink:  r_blink  <= in_wr_data[NUM_LEDS-1:0];
                    c_addr_bright: r_bright <= in_wr_data[PWM_BITS-1:0];
                    c_addr_div:    r_div    <= in_wr_data[1:0];
                    default:       r_div    <= r_div;
                endcase
            end
        end
    end

    assign out_rd_data = r_rd_data;
    assign out_led     = r_led;

endmodule
`default_nettype wire

// File: tb/tb_led_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_bank
// Summary  : Vector table, directed corner sequences and random traffic for
//            led_bank, compared against a cycle-count based reference model.
// Revision : 1.0
// ============================================================================
module tb_led_bank;

    localparam int NL = 5;
    localparam int DW = 16;
    localparam int PB = 2;
    localparam int PS = 8;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [15:0] data;
        logic        chk;
        logic [15:0] exp_rd;
    } vec_t;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [1:0]    addr    = 2'd0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic [NL-1:0] led;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    vec_t vecs [12];

    always #5 clk = ~clk;

    led_bank #(
        .NUM_LEDS      (NL),
        .DATA_WIDTH    (DW),
        .PWM_BITS      (PB),
        .PRESCALE_BITS (PS)
    ) dut (
        .in_clock    (clk),
        .in_reset    (rst),
        .in_wr_en    (wr_en),
        .in_rd_en    (rd_en),
        .in_addr     (addr),
        .in_wr_data  (wr_data),
        .out_rd_data (rd_data),
        .out_led     (led)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks edges since reset and derives every output from the rules directly.
    int unsigned   m_cnt;
    logic [NL-1:0] m_on, m_blink, m_led;
    int unsigned   m_bright, m_div, m_p;
    logic [15:0]   m_rd;
    bit            m_pwm, m_ph;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_on = '0; m_blink = '0; m_led = '0;
            m_bright = 0; m_div = 0; m_rd = '0;
        end else begin
            m_p   = m_cnt % (1 << PS);
            m_pwm = (m_bright == (1 << PB) - 1) || ((m_p % (1 << PB)) < m_bright);
            m_ph  = ((m_p >> (PS - 1 - m_div)) & 1) == 1;
            m_led = m_on & (m_ph ? {NL{1'b1}} : ~m_blink) & (m_pwm ? {NL{1'b1}} : {NL{1'b0}});
            if (rd_en) begin
                case (addr)
                    2'd0: m_rd = 16'(m_on);
                    2'd1: m_rd = 16'(m_blink);
                    2'd2: m_rd = 16'(m_bright);
                    default: m_rd = 16'(m_div);
                endcase
            end
            if (wr_en) begin
                case (addr)
                    2'd0: m_on     = wr_data[NL-1:0];
                    2'd1: m_blink  = wr_data[NL-1:0];
                    2'd2: m_bright = wr_data % (1 << PB);
                    default: m_div = wr_data % 4;
                endcase
            end
            m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("led_vs_model", 32'(led), 32'(m_led));
            check("rd_vs_model", 32'(rd_data), 32'(m_rd));
        end
    end

    task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [15:0] d);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        d = rd_data;
        rd_en = 1'b0;
    endtask

    task automatic measure_blink(input int cycles, input int half, input int min_int, input string tag);
        logic prev;
        int   last;
        int   nint;
        int   bad;
        int   dark0;
        prev = led[1]; last = -1; nint = 0; bad = 0; dark0 = 0;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (!led[0]) dark0++;
            if (led[1] !== prev) begin
                if (last >= 0) begin
                    nint++;
                    if (c - last != half) bad++;
                end
                last = c;
                prev = led[1];
            end
        end
        check({tag, "_led0_dark"}, 32'(dark0), 32'd0);
        check({tag, "_bad_intervals"}, 32'(bad), 32'd0);
        check({tag, "_enough_toggles"}, 32'(nint >= min_int), 32'd1);
    endtask

    initial begin
        logic [15:0] d;
        int          lit;

        vecs[0]  = '{1'b1, 1'b0, 2'd0, 16'hFFFF, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b1, 16'h001F};
        vecs[2]  = '{1'b1, 1'b0, 2'd1, 16'hABCD, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 16'h0000, 1'b1, 16'h000D};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 16'hFFFE, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 2'd2, 16'h0000, 1'b1, 16'h0002};
        vecs[6]  = '{1'b1, 1'b0, 2'd3, 16'h0007, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, 2'd3, 16'h0000, 1'b1, 16'h0003};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 16'h0003};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 16'h0000, 1'b1, 16'h001F};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b1, 16'h0000};
        vecs[11] = '{1'b1, 1'b1, 2'd1, 16'h0012, 1'b1, 16'h000D};

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_led", 32'(led), 32'd0);
        check("reset_rd", 32'(rd_data), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            wr_en = vecs[i].wr; rd_en = vecs[i].rd;
            addr = vecs[i].addr; wr_data = vecs[i].data;
            @(negedge clk);
            if (vecs[i].chk) check($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(vecs[i].exp_rd));
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // Direct drive with one-cycle LED latency
        write_reg(2'd1, 16'h0000);
        write_reg(2'd3, 16'h0000);
        write_reg(2'd2, 16'h0003);
        write_reg(2'd0, 16'h0015);
        check("drive_latency", 32'(led), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drive_steady", 32'(led), 32'h15);
        end
        write_reg(2'd0, 16'hFFFF);
        read_reg(2'd0, d);
        check("on_width_mask", 32'(d), 32'h1F);

        // Asynchronous reset mid-cycle with lit LEDs
        check("pre_reset_led", 32'(led), 32'h1F);
        read_reg(2'd0, d);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_led", 32'(led), 32'd0);
        check("async_reset_rd", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        read_reg(2'd0, d);
        check("post_reset_on", 32'(d), 32'd0);

        // PWM duty
        write_reg(2'd0, 16'h0001);
        write_reg(2'd2, 16'h0001);
        @(negedge clk);
        lit = 0;
        repeat (16) begin @(negedge clk); lit += int'(led[0]); end
        check("pwm_bright1", 32'(lit), 32'd4);
        write_reg(2'd2, 16'h0002);
        @(negedge clk);
        lit = 0;
        repeat (16) begin @(negedge clk); lit += int'(led[0]); end
        check("pwm_bright2", 32'(lit), 32'd8);
        write_reg(2'd2, 16'h0000);
        @(negedge clk);
        lit = 0;
        repeat (16) begin @(negedge clk); lit += int'(led[0]); end
        check("pwm_bright0", 32'(lit), 32'd0);

        // Blink, including prescaler wraps at DIV=0
        write_reg(2'd0, 16'h0003);
        write_reg(2'd1, 16'h0002);
        write_reg(2'd2, 16'h0003);
        write_reg(2'd3, 16'h0000);
        repeat (2) @(negedge clk);
        measure_blink(600, 128, 3, "blink_div0");
        write_reg(2'd3, 16'h0003);
        repeat (20) @(negedge clk);
        measure_blink(100, 16, 4, "blink_div3");

        // Read/write collision
        write_reg(2'd0, 16'h000A);
        wr_en = 1'b1; rd_en = 1'b1; addr = 2'd0; wr_data = 16'h0005;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        check("collision_old", 32'(rd_data), 32'h000A);
        read_reg(2'd0, d);
        check("collision_new", 32'(d), 32'h0005);

        // Random traffic against the model
        repeat (1500) begin
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            addr    = 2'($urandom_range(0, 3));
            wr_data = 16'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
